project_period_counter_master: RTL and testbench
================================================

// Module: project_period_counter_master
// PURPOSE
//  Master timebase of the PWM peripheral; the sync-generating counterpart of project_period_counter_slave.
//  Runs an up, down or up-down period counter and emits a one-cycle o_sync strobe on a selectable count event.
//  o_sync drives the i_phase_en inputs of slave counters, which then load their phase offset.
//  Exports the current and next count for compare/duty logic downstream.
// PARAMETERS
//  WIDTH   16   counter, period and compare width in bits
// PORTS
//  i_clk           in   1      system clock, rising edge
//  i_reset         in   1      asynchronous, active-high reset
//  i_en            in   1      count enable
//  i_mode          in   2      00 stop, 01 up, 10 down, 11 up-down
//  i_sync_en       in   1      1 = o_sync permitted
//  i_sync_sel      in   2      sync event: 00 zero, 01 period, 10 compare_b, 11 zero or period
//  i_compare_b     in   WIDTH  compare value used when i_sync_sel = 10
//  i_period        in   WIDTH  period value P (terminal count)
//  o_period        out  WIDTH  current count (registered)
//  o_period_next   out  WIDTH  value o_period will take at the next edge (combinational)
//  o_dir           out  1      up-down direction: 0 up, 1 down (registered)
//  o_sync          out  1      one-cycle sync strobe (registered)
// BEHAVIOUR
//  - Reset (async): o_period=0, o_dir=0, o_sync=0, active period=0.
//  - Tick = i_en=1 and i_mode!=00. With no tick: count and o_dir hold, o_period_next=o_period, o_sync=0.
//  - Up (01):
//    - cnt<P: cnt+1.
//    - cnt>=P: cnt becomes 0.
//    - o_dir forced 0.
//  - Down (10):
//    - cnt==0: cnt becomes P.
//    - cnt>P: cnt-1; P is not re-clipped.
//    - else: cnt-1.
//    - o_dir forced 1.
//    - The first tick after reset shows P.
//  - Up-down (11), triangle 0..P..0:
//    - o_dir=0 and cnt>=P: o_dir becomes 1, cnt becomes P-1.
//    - o_dir=1 and cnt==0: o_dir becomes 0, cnt becomes 1.
//    - Otherwise: cnt +/-1 per o_dir.
//    - 0 and P are each held for exactly one tick.
//  - P=0 in any mode: cnt stays 0, o_dir=0; every tick is a zero and a period event.
//  - P=1 in up-down: the sequence is 0,1,0,1.
//  - Arithmetic:
//    - Counter arithmetic is modulo 2^WIDTH; no value outside 0..max(P,cnt) is ever produced.
//    - The mode is sampled every tick. A mode change mid-period applies immediately from the current count; there is no restart.
//  - o_sync is registered with cnt and is high in the same cycle o_period shows the event value:
//    - Condition: tick and i_sync_en and event(new cnt).
//    - Events: 00 new cnt==0; 01 new cnt==P; 10 new cnt==i_compare_b; 11 new cnt==0 or new cnt==P.
//    - A compare_b value greater than P never fires.
//    - In up-down with sel=10, o_sync fires twice per triangle: once rising, once falling.
//  - i_sync_en low suppresses o_sync only; counting is unaffected.
//  - Reset mid-period clears everything at once; after release, counting restarts from the reset values.
// CONFIGURATION
//  PROJECT_PERIOD_SHADOW_EN defined:
//  - P comes from a shadow register loaded from i_period:
//    - on every cycle with no tick;
//    - on the tick where new cnt==0 in up mode;
//    - on the tick where new cnt==P_new in down mode, i.e. the reload uses the freshly loaded i_period;
//    - on the tick where new cnt==0 in up-down mode.
//  - i_period changes mid-period take effect only at the period boundary.
//  Not defined:
//  - P = i_period directly, and changes apply on the next tick.
//  - A period reduced below cnt follows the cnt>P rules above.
// TESTING
//  1. Reset, i_en=0, P=15, 16 clocks -> o_period=0 and o_sync=0 throughout. Then en=1, mode=01 -> o_period 1,2..15,0 on successive clocks.
//  2. Up, P=15, sync_sel=00 -> o_sync high exactly when o_period=0, every 16 clocks. Same run with sel=01 -> o_sync only at 15; sel=10, compare_b=5 -> o_sync only at 5.
//  3. Down, P=15 after reset -> 15,14..0,15. Sel=11 -> o_sync at 15 and at 0. i_sync_en=0 -> no o_sync, count unchanged.
//  4. Up-down, P=15 -> 1..15,14..0,1; o_dir rises in the cycle o_period=14 after 15. Sel=10, compare_b=5 -> two strobes per 30-clock triangle.
//  5. Edge periods: P=0 -> o_period stays 0 with o_sync every clock for sel 00/01. P=1 up-down -> 0,1,0,1. Reset asserted at count 9 -> immediate 0, o_sync=0.
//  6. Up, P=15, count 8, i_period changed to 7:
//     - With PROJECT_PERIOD_SHADOW_EN -> counts to 15, wraps to 0, then runs a 0..7 period.
//     - Without -> wraps to 0 on the next tick.

Source files
------------

// File: rtl/project_period_counter_master_if.sv
// ---------------------------------------------------------------------------
// project_period_counter_master_if
//
// Purpose:
//   Groups the control inputs and count outputs of the PWM master timebase
//   so the counter and its consumer share one bundle.
//
// Signals (named from the counter's point of view):
//   i_en           count enable
//   i_mode         00 stop, 01 up, 10 down, 11 up-down
//   i_sync_en      1 = o_sync permitted
//   i_sync_sel     sync event: 00 zero, 01 period, 10 compare_b, 11 zero or period
//   i_compare_b    compare value used for the compare_b sync event
//   i_period       period value P (terminal count)
//   o_period       current count (registered)
//   o_period_next  value o_period takes at the next edge (combinational)
//   o_dir          up-down direction, 0 up / 1 down (registered)
//   o_sync         one-cycle sync strobe (registered)
//
// Modports:
//   master  the counter itself (drives the o_* signals)
//   slave   the consumer / controller (drives the i_* signals)
// ---------------------------------------------------------------------------
interface project_period_counter_master_if #(
  parameter int WIDTH = 16
);

  logic             i_en;
  logic [1:0]       i_mode;
  logic             i_sync_en;
  logic [1:0]       i_sync_sel;
  logic [WIDTH-1:0] i_compare_b;
  logic [WIDTH-1:0] i_period;
  logic [WIDTH-1:0] o_period;
  logic [WIDTH-1:0] o_period_next;
  logic             o_dir;
  logic             o_sync;

  modport master (
    input  i_en,
    input  i_mode,
    input  i_sync_en,
    input  i_sync_sel,
    input  i_compare_b,
    input  i_period,
    output o_period,
    output o_period_next,
    output o_dir,
    output o_sync
  );

  modport slave (
    output i_en,
    output i_mode,
    output i_sync_en,
    output i_sync_sel,
    output i_compare_b,
    output i_period,
    input  o_period,
    input  o_period_next,
    input  o_dir,
    input  o_sync
  );

endinterface

// File: rtl/project_period_counter_master.sv
// ---------------------------------------------------------------------------
// project_period_counter_master
//
// Purpose:
//   Master timebase of the PWM peripheral. Runs an up, down or up-down
//   (triangle) period counter and emits a one-cycle o_sync strobe on a
//   selectable count event. o_sync feeds the phase-enable inputs of slave
//   counters. The current and next count are exported for downstream
//   compare/duty logic.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous, active-high reset
//   ctrl     project_period_counter_master_if.master bundle
//            (i_en, i_mode, i_sync_en, i_sync_sel, i_compare_b, i_period,
//             o_period, o_period_next, o_dir, o_sync)
//
// Parameters:
//   WIDTH    counter, period and compare width in bits (default 16)
//
// Configuration macro:
//   PROJECT_PERIOD_SHADOW_EN
//     defined     : the active period comes from a shadow register that
//                   only picks up i_period while idle or at a period
//                   boundary, so mid-period changes wait for the boundary.
//     not defined : i_period is used directly and applies on the next tick.
// ---------------------------------------------------------------------------
module project_period_counter_master #(
  parameter int WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  project_period_counter_master_if.master ctrl
);

  typedef enum logic [1:0] {
    MODE_STOP   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_UPDOWN = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    SYNC_ZERO        = 2'b00,
    SYNC_PERIOD      = 2'b01,
    SYNC_COMPARE_B   = 2'b10,
    SYNC_ZERO_PERIOD = 2'b11
  } sync_sel_t;

  mode_t            mode;
  sync_sel_t        sync_sel;
  logic             tick;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_n;
  logic             dir_q;
  logic             dir_n;
  logic             sync_q;
  logic             sync_n;

  // p_cur is the period governing this tick; p_next is the period that
  // goes with the new count and is what the sync events compare against.
  logic [WIDTH-1:0] p_cur;
  logic [WIDTH-1:0] p_next;

  logic             evt_zero;
  logic             evt_period;
  logic             evt_compare_b;
  logic             evt_hit;

  assign mode     = mode_t'(ctrl.i_mode);
  assign sync_sel = sync_sel_t'(ctrl.i_sync_sel);
  assign tick     = ctrl.i_en && (mode != MODE_STOP);

  // Next count and direction. Without a tick everything holds. The down
  // reload always takes i_period directly: with the shadow register that
  // is the freshly loaded value, without it it is the live period anyway.
  // A zero period pins the counter at 0 counting up in every mode.
  always_comb begin
    cnt_n = cnt_q;
    dir_n = dir_q;
    if (tick) begin
      unique case (mode)
        MODE_UP: begin
          dir_n = 1'b0;
          if (cnt_q >= p_cur) begin
            cnt_n = '0;
          end else begin
            cnt_n = cnt_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (cnt_q == '0) begin
            cnt_n = ctrl.i_period;
            dir_n = (ctrl.i_period != '0);
          end else begin
            cnt_n = cnt_q - WIDTH'(1);
            dir_n = (p_cur != '0);
          end
        end
        MODE_UPDOWN: begin
          if (p_cur == '0) begin
            cnt_n = '0;
            dir_n = 1'b0;
          end else if (!dir_q && (cnt_q >= p_cur)) begin
            // Top of the triangle: P is shown for one tick only.
            cnt_n = p_cur - WIDTH'(1);
            dir_n = 1'b1;
          end else if (dir_q && (cnt_q == '0)) begin
            // Bottom of the triangle: 0 is shown for one tick only.
            cnt_n = WIDTH'(1);
            dir_n = 1'b0;
          end else if (dir_q) begin
            cnt_n = cnt_q - WIDTH'(1);
          end else begin
            cnt_n = cnt_q + WIDTH'(1);
          end
        end
        MODE_STOP: begin
        end
      endcase
    end
  end

`ifdef PROJECT_PERIOD_SHADOW_EN
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_n;

  // Shadow period reload points: every idle cycle, and on the tick that
  // lands on the period boundary of the current mode. In down mode the
  // boundary is the reload to the new period value.
  always_comb begin
    period_n = period_q;
    if (!tick) begin
      period_n = ctrl.i_period;
    end else begin
      unique case (mode)
        MODE_UP:     if (cnt_n == '0)            period_n = ctrl.i_period;
        MODE_DOWN:   if (cnt_n == ctrl.i_period) period_n = ctrl.i_period;
        MODE_UPDOWN: if (cnt_n == '0)            period_n = ctrl.i_period;
        MODE_STOP: begin
        end
      endcase
    end
  end

  // Shadow period register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      period_q <= '0;
    end else begin
      period_q <= period_n;
    end
  end

  assign p_cur  = period_q;
  assign p_next = period_n;
`else
  assign p_cur  = ctrl.i_period;
  assign p_next = ctrl.i_period;
`endif

  // Sync events are judged on the new count so the strobe lines up with
  // the cycle in which o_period shows the event value. A compare_b value
  // beyond the period is never a legal event, even if a shrinking period
  // leaves the count briefly above it.
  always_comb begin
    evt_zero      = (cnt_n == '0);
    evt_period    = (cnt_n == p_next);
    evt_compare_b = (cnt_n == ctrl.i_compare_b) && (ctrl.i_compare_b <= p_next);
    evt_hit       = 1'b0;
    unique case (sync_sel)
      SYNC_ZERO:        evt_hit = evt_zero;
      SYNC_PERIOD:      evt_hit = evt_period;
      SYNC_COMPARE_B:   evt_hit = evt_compare_b;
      SYNC_ZERO_PERIOD: evt_hit = evt_zero || evt_period;
    endcase
    sync_n = tick && ctrl.i_sync_en && evt_hit;
  end

  // Count, direction and sync registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_n;
      dir_q  <= dir_n;
      sync_q <= sync_n;
    end
  end

  assign ctrl.o_period      = cnt_q;
  assign ctrl.o_period_next = cnt_n;
  assign ctrl.o_dir         = dir_q;
  assign ctrl.o_sync        = sync_q;

endmodule

// File: tb/tb_project_period_counter_master.sv
// ---------------------------------------------------------------------------
// tb_project_period_counter_master
//
// Purpose:
//   Self-checking bench for project_period_counter_master. The stimulus
//   process drives one cycle of inputs per call and queues the count,
//   direction and sync values expected after the following clock edge;
//   an independent monitor pops and compares one entry per clock edge.
//   Expected sequences are closed-form per test (k mod 16, triangle
//   position, and so on). Build with PROJECT_PERIOD_SHADOW_EN defined to
//   exercise the shadow-period variant.
// ---------------------------------------------------------------------------
module tb_project_period_counter_master;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             sync;
  } exp_t;

  logic clk;
  logic rst;

  project_period_counter_master_if #(.WIDTH(WIDTH)) bus ();

  project_period_counter_master #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .ctrl    (bus)
  );

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  logic             cur_rst;
  logic [1:0]       cur_mode;
  logic             cur_sync_en;
  logic [1:0]       cur_sel;
  logic [WIDTH-1:0] cur_cmp;
  logic [WIDTH-1:0] cur_per;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the
  // outputs must show after the next rising edge.
  task automatic apply_stimulus(input logic en, input int e_cnt, input logic e_dir,
                                input logic e_sync);
    exp_t e;
    @(negedge clk);
    rst             = cur_rst;
    bus.i_en        = en;
    bus.i_mode      = cur_mode;
    bus.i_sync_en   = cur_sync_en;
    bus.i_sync_sel  = cur_sel;
    bus.i_compare_b = cur_cmp;
    bus.i_period    = cur_per;
    e.cnt  = WIDTH'(e_cnt);
    e.dir  = e_dir;
    e.sync = e_sync;
    sb_q.push_back(e);
  endtask

  // One reset cycle plus one idle cycle so a shadow period can load.
  task automatic do_reset();
    cur_rst = 1'b1;
    apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    cur_rst = 1'b0;
    apply_stimulus(1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: o_period_next is sampled before the edge updates the
  // registers, the registered outputs just after it.
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] nxt;
    forever begin
      @(posedge clk);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        nxt = bus.o_period_next;
        #1;
        check_output("period", bus.o_period, e.cnt);
        check_output("period_next", nxt, e.cnt);
        check_output("dir", WIDTH'(bus.o_dir), WIDTH'(e.dir));
        check_output("sync", WIDTH'(bus.o_sync), WIDTH'(e.sync));
      end
    end
  end

  initial begin
    int k;
    int c;
    int t;
    logic d;

    tests_run    = 0;
    tests_failed = 0;
    rst             = 1'b1;
    bus.i_en        = 1'b0;
    bus.i_mode      = 2'b00;
    bus.i_sync_en   = 1'b0;
    bus.i_sync_sel  = 2'b00;
    bus.i_compare_b = '0;
    bus.i_period    = WIDTH'(15);
    cur_rst     = 1'b1;
    cur_mode    = 2'b01;
    cur_sync_en = 1'b0;
    cur_sel     = 2'b00;
    cur_cmp     = '0;
    cur_per     = WIDTH'(15);

    // Reset state, then 16 idle clocks with the enable low.
    repeat (2) apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    cur_rst = 1'b0;
    repeat (16) apply_stimulus(1'b0, 0, 1'b0, 1'b0);

    // Up count 1..15,0 with sync disabled.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      k++;
      apply_stimulus(1'b1, k % 16, 1'b0, 1'b0);
    end

    // Up count with each sync event selection.
    cur_sync_en = 1'b1;
    cur_sel     = 2'b00;
    for (int i = 0; i < 32; i++) begin
      k++; c = k % 16;
      apply_stimulus(1'b1, c, 1'b0, c == 0);
    end
    cur_sel = 2'b01;
    for (int i = 0; i < 16; i++) begin
      k++; c = k % 16;
      apply_stimulus(1'b1, c, 1'b0, c == 15);
    end
    cur_sel = 2'b10;
    cur_cmp = WIDTH'(5);
    for (int i = 0; i < 16; i++) begin
      k++; c = k % 16;
      apply_stimulus(1'b1, c, 1'b0, c == 5);
    end
    cur_cmp = WIDTH'(20);
    for (int i = 0; i < 16; i++) begin
      k++; c = k % 16;
      apply_stimulus(1'b1, c, 1'b0, 1'b0);
    end

    // Down count after reset: 15,14..0,15 with zero-or-period sync.
    cur_mode = 2'b10;
    cur_sel  = 2'b11;
    do_reset();
    for (k = 1; k <= 32; k++) begin
      c = (16 - (k % 16)) % 16;
      apply_stimulus(1'b1, c, 1'b1, (c == 0) || (c == 15));
    end
    cur_sync_en = 1'b0;
    for (k = 33; k <= 48; k++) begin
      c = (16 - (k % 16)) % 16;
      apply_stimulus(1'b1, c, 1'b1, 1'b0);
    end

    // Up-down triangle, 30 ticks per period, compare_b strobes twice.
    cur_mode    = 2'b11;
    cur_sel     = 2'b10;
    cur_cmp     = WIDTH'(5);
    cur_sync_en = 1'b1;
    do_reset();
    for (k = 1; k <= 62; k++) begin
      t = k % 30;
      c = (t <= 15) ? t : 30 - t;
      d = (t >= 16) || (t == 0);
      apply_stimulus(1'b1, c, d, c == 5);
    end

    // Zero period in every mode: pinned at 0, strobe every tick.
    cur_per  = '0;
    cur_mode = 2'b01;
    cur_sel  = 2'b00;
    do_reset();
    repeat (4) apply_stimulus(1'b1, 0, 1'b0, 1'b1);
    cur_sel = 2'b01;
    repeat (4) apply_stimulus(1'b1, 0, 1'b0, 1'b1);
    cur_mode = 2'b10;
    cur_sel  = 2'b00;
    repeat (4) apply_stimulus(1'b1, 0, 1'b0, 1'b1);
    cur_mode = 2'b11;
    cur_sel  = 2'b01;
    repeat (4) apply_stimulus(1'b1, 0, 1'b0, 1'b1);

    // Period 1 up-down: 1,0,1,0...
    cur_per  = WIDTH'(1);
    cur_mode = 2'b11;
    cur_sel  = 2'b00;
    do_reset();
    for (k = 1; k <= 6; k++) begin
      c = k % 2;
      apply_stimulus(1'b1, c, c == 0, c == 0);
    end

    // Asynchronous reset at count 9 while the compare strobe is high.
    cur_per  = WIDTH'(15);
    cur_mode = 2'b01;
    cur_sel  = 2'b10;
    cur_cmp  = WIDTH'(9);
    do_reset();
    for (k = 1; k <= 9; k++) apply_stimulus(1'b1, k, 1'b0, k == 9);
    cur_rst = 1'b1;
    apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    #1;
    check_output("async_reset_period", bus.o_period, '0);
    check_output("async_reset_sync", WIDTH'(bus.o_sync), '0);
    cur_rst = 1'b0;
    apply_stimulus(1'b0, 0, 1'b0, 1'b0);
    for (k = 1; k <= 3; k++) apply_stimulus(1'b1, k, 1'b0, 1'b0);

    // Period shrinks from 15 to 7 while the count sits at 8.
    cur_per  = WIDTH'(15);
    cur_mode = 2'b01;
    cur_sel  = 2'b00;
    do_reset();
    for (k = 1; k <= 8; k++) apply_stimulus(1'b1, k, 1'b0, 1'b0);
    cur_per = WIDTH'(7);
`ifdef PROJECT_PERIOD_SHADOW_EN
    for (k = 9; k <= 15; k++) apply_stimulus(1'b1, k, 1'b0, 1'b0);
`endif
    apply_stimulus(1'b1, 0, 1'b0, 1'b1);
    for (k = 1; k <= 7; k++) apply_stimulus(1'b1, k, 1'b0, 1'b0);
    apply_stimulus(1'b1, 0, 1'b0, 1'b1);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    check_output("scoreboard_drain", WIDTH'(sb_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
